// File: rtl/otbn_rf_base_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : otbn_rf_base_wb_queue
// Description : In-order write-back queue in front of the 32b GPR write port.
//               Merges ALU results (no integrity) and LSU loads (39b
//               integrity), holds them across controller stalls and flags
//               read-after-write hazards on two GPR read addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module otbn_rf_base_wb_queue #(
    parameter int QUEUE_DEPTH     = 2,
    parameter int BASE_INTG_WIDTH = 39
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,

    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [4:0]                 alu_addr_i,
    input  logic [31:0]                alu_data_i,

    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [4:0]                 lsu_addr_i,
    input  logic [BASE_INTG_WIDTH-1:0] lsu_data_intg_i,

    output logic [4:0]                 rf_wr_addr_o,
    output logic                       rf_wr_en_o,
    output logic [31:0]                rf_wr_data_no_intg_o,
    output logic [BASE_INTG_WIDTH-1:0] rf_wr_data_intg_o,
    output logic                       rf_wr_data_intg_sel_o,
    output logic                       rf_wr_commit_o,
    input  logic                       rf_wr_stall_i,

    input  logic [4:0]                 hz_addr_a_i,
    input  logic [4:0]                 hz_addr_b_i,
    output logic                       hz_a_o,
    output logic                       hz_b_o,

    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(QUEUE_DEPTH);

    // Entry storage and queue bookkeeping
    logic [4:0]                 addr_q [QUEUE_DEPTH];
    logic [4:0]                 addr_d [QUEUE_DEPTH];
    logic                       sel_q  [QUEUE_DEPTH];
    logic                       sel_d  [QUEUE_DEPTH];
    logic [BASE_INTG_WIDTH-1:0] data_q [QUEUE_DEPTH];
    logic [BASE_INTG_WIDTH-1:0] data_d [QUEUE_DEPTH];
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [CNT_W-1:0]           count_q, count_d;

    logic [CNT_W-1:0]           w_free;
    logic [CNT_W-1:0]           w_alu_need;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_push_lsu;
    logic                       w_push_alu;
    logic                       w_pop;
    logic [PTR_W-1:0]           w_alu_wptr;

    assign w_free     = C_DEPTH - count_q;
    assign w_alu_need = CNT_W'(1) + CNT_W'(lsu_valid_i);
    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == C_DEPTH);

    // Readiness depends only on registered occupancy: no pop-through.
    assign lsu_ready_o = ~rst_i & ~flush_i & (w_free >= CNT_W'(1));
    assign alu_ready_o = ~rst_i & ~flush_i & (w_free >= w_alu_need);

    assign w_push_lsu = lsu_valid_i & lsu_ready_o;
    assign w_push_alu = alu_valid_i & alu_ready_o;

    assign rf_wr_en_o     = ~w_empty & ~flush_i & ~rst_i;
    assign rf_wr_commit_o = rf_wr_en_o & ~rf_wr_stall_i;
    assign w_pop          = rf_wr_commit_o;

    // LSU entry is the older one when both arrive together.
    assign w_alu_wptr = wptr_q + PTR_W'(w_push_lsu);

    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            addr_d[i] = addr_q[i];
            sel_d[i]  = sel_q[i];
            data_d[i] = data_q[i];
        end
        if (w_push_lsu) begin
            addr_d[wptr_q] = lsu_addr_i;
            sel_d[wptr_q]  = 1'b1;
            data_d[wptr_q] = lsu_data_intg_i;
        end
        if (w_push_alu) begin
            addr_d[w_alu_wptr] = alu_addr_i;
            sel_d[w_alu_wptr]  = 1'b0;
            data_d[w_alu_wptr] = {{(BASE_INTG_WIDTH-32){1'b0}}, alu_data_i};
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + PTR_W'(w_push_lsu) + PTR_W'(w_push_alu);
            rptr_d  = rptr_q + PTR_W'(w_pop);
            count_d = count_q + CNT_W'(w_push_lsu) + CNT_W'(w_push_alu)
                      - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                addr_q[i] <= '0;
                sel_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                sel_q[i]  <= sel_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Head is read straight from storage, so writes appear one cycle after accept.
    assign rf_wr_addr_o          = addr_q[rptr_q];
    assign rf_wr_data_intg_sel_o = sel_q[rptr_q];
    assign rf_wr_data_intg_o     = data_q[rptr_q];
    assign rf_wr_data_no_intg_o  = data_q[rptr_q][31:0];

    assign empty_o = w_empty;
    assign full_o  = w_full;

    // Hazard scan walks the live window starting at the read pointer; x0 never flags.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hz_a_o = 1'b0;
        hz_b_o = 1'b0;
        idx    = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            idx = rptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((addr_q[idx] == hz_addr_a_i) && (hz_addr_a_i != 5'd0)) begin
                    hz_a_o = 1'b1;
                end
                if ((addr_q[idx] == hz_addr_b_i) && (hz_addr_b_i != 5'd0)) begin
                    hz_b_o = 1'b1;
                end
            end
        end
    end

    a_count_range : assert property (@(posedge clk_i) count_q <= C_DEPTH);
    a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
        w_full |-> !(w_push_lsu || w_push_alu));
    a_no_en_empty : assert property (@(posedge clk_i) w_empty |-> !rf_wr_en_o);

endmodule
`default_nettype wire

// File: tb/tb_otbn_rf_base_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_otbn_rf_base_wb_queue
// Description : Directed self-checking bench for the GPR write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otbn_rf_base_wb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_addr = '0;
    logic [38:0] lsu_data = '0;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data_no_intg;
    logic [38:0] wr_data_intg;
    logic        wr_sel;
    logic        wr_commit;
    logic        stall = 1'b0;
    logic [4:0]  hz_addr_a = '0;
    logic [4:0]  hz_addr_b = '0;
    logic        hz_a, hz_b, empty, full;

    int n_checks = 0;
    int n_errors = 0;
    int n_commits = 0;
    int commits_before;

    always #5 clk = ~clk;

    otbn_rf_base_wb_queue #(.QUEUE_DEPTH(2), .BASE_INTG_WIDTH(39)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .alu_valid_i           (alu_valid),
        .alu_ready_o           (alu_ready),
        .alu_addr_i            (alu_addr),
        .alu_data_i            (alu_data),
        .lsu_valid_i           (lsu_valid),
        .lsu_ready_o           (lsu_ready),
        .lsu_addr_i            (lsu_addr),
        .lsu_data_intg_i       (lsu_data),
        .rf_wr_addr_o          (wr_addr),
        .rf_wr_en_o            (wr_en),
        .rf_wr_data_no_intg_o  (wr_data_no_intg),
        .rf_wr_data_intg_o     (wr_data_intg),
        .rf_wr_data_intg_sel_o (wr_sel),
        .rf_wr_commit_o        (wr_commit),
        .rf_wr_stall_i         (stall),
        .hz_addr_a_i           (hz_addr_a),
        .hz_addr_b_i           (hz_addr_b),
        .hz_a_o                (hz_a),
        .hz_b_o                (hz_b),
        .empty_o               (empty),
        .full_o                (full)
    );

    always @(posedge clk) begin
        if (wr_commit) n_commits++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let combinational outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_both(input logic [4:0] la, input logic [38:0] ld,
                             input logic [4:0] aa, input logic [31:0] ad);
        lsu_valid = 1'b1; lsu_addr = la; lsu_data = ld;
        alu_valid = 1'b1; alu_addr = aa; alu_data = ad;
        tick();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        settle();
    endtask

    initial begin
        // Reset behaviour
        tick(); tick();
        check("rst_alu_ready", alu_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_wr_en", wr_en, 0);
        rst = 1'b0;
        settle();
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_hz", {hz_a, hz_b}, 0);
        check("idle_alu_ready", alu_ready, 1);
        check("idle_lsu_ready", lsu_ready, 1);

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678;
        tick();
        alu_valid = 1'b0;
        settle();
        check("alu_en", wr_en, 1);
        check("alu_commit", wr_commit, 1);
        check("alu_sel", wr_sel, 0);
        check("alu_addr", wr_addr, 5);
        check("alu_data", wr_data_no_intg, 32'h1234_5678);
        check("alu_data_intg", wr_data_intg, 39'h00_1234_5678);
        tick();
        check("alu_drained", empty, 1);

        // Simultaneous LSU + ALU: LSU is older
        lsu_valid = 1'b1; alu_valid = 1'b1;
        settle();
        check("both_lsu_ready", lsu_ready, 1);
        check("both_alu_ready", alu_ready, 1);
        lsu_addr = 5'd3; lsu_data = 39'h55_AABB_CCDD;
        alu_addr = 5'd4; alu_data = 32'hCAFE_F00D;
        tick();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        settle();
        check("both_full", full, 1);
        check("both_first_sel", wr_sel, 1);
        check("both_first_addr", wr_addr, 3);
        check("both_first_data", wr_data_intg, 39'h55_AABB_CCDD);
        check("both_first_commit", wr_commit, 1);
        tick();
        check("both_second_sel", wr_sel, 0);
        check("both_second_addr", wr_addr, 4);
        check("both_second_data", wr_data_no_intg, 32'hCAFE_F00D);
        tick();
        check("both_drained", empty, 1);

        // One entry queued, LSU also valid: ALU needs two free slots
        stall = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h1;
        tick();
        alu_valid = 1'b1; lsu_valid = 1'b1;
        settle();
        check("one_free_lsu_ready", lsu_ready, 1);
        check("one_free_alu_ready", alu_ready, 0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        stall = 1'b0;
        tick();
        check("one_free_drained", empty, 1);

        // Fill under stall, head must hold
        stall = 1'b1;
        push_both(5'd9, 39'h7F_0000_0009, 5'd10, 32'h0000_000A);
        lsu_valid = 1'b1; alu_valid = 1'b1;
        settle();
        check("stall_full", full, 1);
        check("stall_ready", {lsu_ready, alu_ready}, 0);
        check("stall_en", wr_en, 1);
        check("stall_commit", wr_commit, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_head_addr", wr_addr, 9);
            check("stall_head_data", wr_data_intg, 39'h7F_0000_0009);
        end
        lsu_valid = 1'b0; alu_valid = 1'b0;
        stall = 1'b0;
        settle();
        check("release_first", {wr_commit, wr_sel, wr_addr}, {1'b1, 1'b1, 5'd9});
        tick();
        check("release_second", {wr_commit, wr_sel, wr_addr}, {1'b1, 1'b0, 5'd10});
        tick();
        check("release_empty", empty, 1);

        // Hazard detection
        stall = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        hz_addr_a = 5'd7; hz_addr_b = 5'd0;
        settle();
        check("hz_a_set", hz_a, 1);
        check("hz_b_zero", hz_b, 0);
        hz_addr_b = 5'd6;
        settle();
        check("hz_b_other", hz_b, 0);
        stall = 1'b0;
        tick();
        check("hz_a_cleared", hz_a, 0);

        // Address 0 never flags even when queued
        stall = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd0;
        tick();
        alu_valid = 1'b0; hz_addr_a = 5'd0; hz_addr_b = 5'd0;
        settle();
        check("hz_x0", {hz_a, hz_b}, 0);
        stall = 1'b0;
        tick();

        // Flush with two queued entries
        stall = 1'b1;
        push_both(5'd11, 39'h1, 5'd12, 32'h2);
        hz_addr_a = 5'd11; hz_addr_b = 5'd12;
        settle();
        check("pre_flush_hz", {hz_a, hz_b}, 2'b11);
        commits_before = n_commits;
        flush = 1'b1; stall = 1'b0;
        settle();
        check("flush_en", wr_en, 0);
        check("flush_commit", wr_commit, 0);
        check("flush_ready", {lsu_ready, alu_ready}, 0);
        tick();
        flush = 1'b0;
        settle();
        check("post_flush_empty", empty, 1);
        check("post_flush_en", wr_en, 0);
        check("post_flush_hz", {hz_a, hz_b}, 0);
        check("flush_no_commit", n_commits, commits_before);

        // Reset mid-stall with a full queue
        stall = 1'b1;
        push_both(5'd13, 39'h3, 5'd14, 32'h4);
        check("prerst_full", full, 1);
        tick();
        commits_before = n_commits;
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        settle();
        check("rst_mid_empty", empty, 1);
        check("rst_mid_ready", {lsu_ready, alu_ready}, 2'b11);
        check("rst_mid_en", wr_en, 0);
        tick();
        check("rst_mid_no_commit", n_commits, commits_before);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
